// File: rtl/icache_refill_tracker_if.sv
// Bundles the cache request/return side and the AXI shim read side of the refill tracker.
// The tracker takes the slave view; the cache/shim environment takes the master view.
interface icache_refill_tracker_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128,
    parameter int TidWidth  = 2,
    parameter int IdWidth   = 4
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i;
    logic                 req_nc_i;
    logic [TidWidth-1:0]  req_tid_i;

    logic                 rd_req_o;
    logic                 rd_gnt_i;
    logic [AddrWidth-1:0] rd_addr_o;
    logic [7:0]           rd_blen_o;
    logic [IdWidth-1:0]   rd_id_o;

    logic                 rd_valid_i;
    logic                 rd_last_i;
    logic [DataWidth-1:0] rd_data_i;
    logic [IdWidth-1:0]   rd_id_i;

    logic                 rtrn_vld_o;
    logic                 rtrn_rdy_i;
    logic [LineWidth-1:0] rtrn_data_o;
    logic [TidWidth-1:0]  rtrn_tid_o;
    logic                 rtrn_nc_o;
    logic                 unexp_beat_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_nc_i, req_tid_i,
        input  rd_gnt_i, rd_valid_i, rd_last_i, rd_data_i, rd_id_i, rtrn_rdy_i,
        output req_ready_o, rd_req_o, rd_addr_o, rd_blen_o, rd_id_o,
        output rtrn_vld_o, rtrn_data_o, rtrn_tid_o, rtrn_nc_o, unexp_beat_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_nc_i, req_tid_i,
        output rd_gnt_i, rd_valid_i, rd_last_i, rd_data_i, rd_id_i, rtrn_rdy_i,
        input  req_ready_o, rd_req_o, rd_addr_o, rd_blen_o, rd_id_o,
        input  rtrn_vld_o, rtrn_data_o, rtrn_tid_o, rtrn_nc_o, unexp_beat_o
    );
endinterface

// File: rtl/icache_refill_tracker.sv
// Tracks outstanding I-cache refill/bypass reads, one slot per AXI ID, assembling
// possibly interleaved beats into whole lines returned with their cache transaction ID.
module icache_refill_tracker #(
    parameter int NumOutstanding = 2,
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int LineWidth      = 128,
    parameter int TidWidth       = 2,
    parameter int IdWidth        = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    icache_refill_tracker_if.slave bus
);
    localparam int Words = LineWidth / DataWidth;
    localparam int SlotW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int WordW = (Words > 1) ? $clog2(Words) : 1;
    localparam int CntW  = $clog2(Words + 1);
    localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'(LineWidth / 8 - 1));
    localparam logic [AddrWidth-1:0] BeatMask = ~(AddrWidth'(DataWidth / 8 - 1));

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_ISSUE,
        SLOT_WAIT,
        SLOT_DONE
    } slot_state_e;

    slot_state_e                       slot_state [NumOutstanding];
    logic [AddrWidth-1:0]              slot_addr  [NumOutstanding];
    logic [TidWidth-1:0]               slot_tid   [NumOutstanding];
    logic                              slot_nc    [NumOutstanding];
    logic [CntW-1:0]                   slot_cnt   [NumOutstanding];
    logic [Words-1:0][DataWidth-1:0]   slot_data  [NumOutstanding];

    logic             issue_lock, rtrn_lock, unexp_q;
    logic [SlotW-1:0] issue_ptr, rtrn_ptr;

    logic             free_any, issue_any, done_any;
    logic [SlotW-1:0] free_idx, issue_low, done_low, issue_sel, rtrn_sel;
    logic [SlotW-1:0] beat_slot;
    logic [WordW-1:0] beat_word;
    logic             beat_ok, beat_room, req_fire;

    // Lowest-index search per state; the lock registers keep a presented slot
    // on the bus until its handshake even if a lower slot reaches that state.
    always_comb begin
        free_any  = 1'b0;
        issue_any = 1'b0;
        done_any  = 1'b0;
        free_idx  = '0;
        issue_low = '0;
        done_low  = '0;
        for (int i = NumOutstanding - 1; i >= 0; i--) begin
            if (slot_state[i] == SLOT_FREE) begin
                free_any = 1'b1;
                free_idx = SlotW'(i);
            end
            if (slot_state[i] == SLOT_ISSUE) begin
                issue_any = 1'b1;
                issue_low = SlotW'(i);
            end
            if (slot_state[i] == SLOT_DONE) begin
                done_any = 1'b1;
                done_low = SlotW'(i);
            end
        end
        issue_sel = issue_lock ? issue_ptr : issue_low;
        rtrn_sel  = rtrn_lock ? rtrn_ptr : done_low;
    end

    assign req_fire  = bus.req_valid_i && free_any;
    assign beat_slot = SlotW'(bus.rd_id_i);
    assign beat_word = WordW'(slot_cnt[beat_slot]);
    assign beat_room = slot_cnt[beat_slot] < CntW'(Words);
    assign beat_ok   = bus.rd_valid_i && (32'(bus.rd_id_i) < 32'(NumOutstanding))
                       && (slot_state[beat_slot] == SLOT_WAIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumOutstanding; i++) begin
                slot_state[i] <= SLOT_FREE;
                slot_addr[i]  <= '0;
                slot_tid[i]   <= '0;
                slot_nc[i]    <= 1'b0;
                slot_cnt[i]   <= '0;
                slot_data[i]  <= '0;
            end
            issue_lock <= 1'b0;
            rtrn_lock  <= 1'b0;
            issue_ptr  <= '0;
            rtrn_ptr   <= '0;
            unexp_q    <= 1'b0;
        end else begin
            unexp_q    <= bus.rd_valid_i && !beat_ok;
            issue_lock <= issue_any && !bus.rd_gnt_i;
            issue_ptr  <= issue_sel;
            rtrn_lock  <= done_any && !bus.rtrn_rdy_i;
            rtrn_ptr   <= rtrn_sel;

            if (req_fire) begin
                slot_state[free_idx] <= SLOT_ISSUE;
                slot_addr[free_idx]  <= bus.req_addr_i & (bus.req_nc_i ? BeatMask : LineMask);
                slot_tid[free_idx]   <= bus.req_tid_i;
                slot_nc[free_idx]    <= bus.req_nc_i;
                slot_cnt[free_idx]   <= '0;
                slot_data[free_idx]  <= '0;
            end

            if (issue_any && bus.rd_gnt_i) begin
                slot_state[issue_sel] <= SLOT_WAIT;
            end

            // Excess beats past a full line are dropped rather than wrapping onto word 0.
            if (beat_ok) begin
                if (beat_room) begin
                    slot_data[beat_slot][beat_word] <= bus.rd_data_i;
                    slot_cnt[beat_slot]             <= slot_cnt[beat_slot] + CntW'(1);
                end
                if (bus.rd_last_i) begin
                    slot_state[beat_slot] <= SLOT_DONE;
                    slot_cnt[beat_slot]   <= '0;
                end
            end

            if (done_any && bus.rtrn_rdy_i) begin
                slot_state[rtrn_sel] <= SLOT_FREE;
            end
        end
    end

    assign bus.req_ready_o  = free_any;
    assign bus.rd_req_o     = issue_any;
    assign bus.rd_addr_o    = issue_any ? slot_addr[issue_sel] : '0;
    assign bus.rd_blen_o    = (issue_any && !slot_nc[issue_sel]) ? 8'(Words - 1) : 8'd0;
    assign bus.rd_id_o      = issue_any ? IdWidth'(issue_sel) : '0;
    assign bus.rtrn_vld_o   = done_any;
    assign bus.rtrn_data_o  = done_any ? slot_data[rtrn_sel] : '0;
    assign bus.rtrn_tid_o   = done_any ? slot_tid[rtrn_sel] : '0;
    assign bus.rtrn_nc_o    = done_any && slot_nc[rtrn_sel];
    assign bus.unexp_beat_o = unexp_q;
endmodule

// File: tb/tb_icache_refill_tracker.sv
// Directed bench for icache_refill_tracker: drives one step per clock from a single
// initial block and checks outputs shortly after each rising edge against hand-worked values.
module tb_icache_refill_tracker;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    icache_refill_tracker_if bus ();

    icache_refill_tracker dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives every input for one cycle, then returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic reqValid, input logic [63:0] reqAddr,
                                 input logic reqNc, input logic [1:0] reqTid,
                                 input logic gnt, input logic beatValid, input logic beatLast,
                                 input logic [63:0] beatData, input logic [3:0] beatId,
                                 input logic rtrnRdy);
        bus.req_valid_i = reqValid;
        bus.req_addr_i  = reqAddr;
        bus.req_nc_i    = reqNc;
        bus.req_tid_i   = reqTid;
        bus.rd_gnt_i    = gnt;
        bus.rd_valid_i  = beatValid;
        bus.rd_last_i   = beatLast;
        bus.rd_data_i   = beatData;
        bus.rd_id_i     = beatId;
        bus.rtrn_rdy_i  = rtrnRdy;
        @(posedge clk);
        #1;
    endtask

    task automatic doRequest(input logic [63:0] addr, input logic nc, input logic [1:0] tid,
                             input logic gnt);
        applyStimulus(1'b1, addr, nc, tid, gnt, 1'b0, 1'b0, 64'd0, 4'd0, 1'b0);
    endtask

    task automatic doBeat(input logic [3:0] id, input logic [63:0] data, input logic last,
                          input logic rdy);
        applyStimulus(1'b0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b1, last, data, id, rdy);
    endtask

    task automatic doIdle(input logic gnt, input logic rdy);
        applyStimulus(1'b0, 64'd0, 1'b0, 2'd0, gnt, 1'b0, 1'b0, 64'd0, 4'd0, rdy);
    endtask

    initial begin
        rst = 1'b1;
        doIdle(1'b0, 1'b0);
        doIdle(1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("rst_ready", 128'(bus.req_ready_o), 128'd1);
        checkOutput("rst_rdreq", 128'(bus.rd_req_o), 128'd0);
        checkOutput("rst_vld", 128'(bus.rtrn_vld_o), 128'd0);
        checkOutput("rst_unexp", 128'(bus.unexp_beat_o), 128'd0);
        checkOutput("rst_addr", 128'(bus.rd_addr_o), 128'd0);
        checkOutput("rst_data", bus.rtrn_data_o, 128'd0);

        // Single cacheable refill
        doRequest(64'h8000_0014, 1'b0, 2'd1, 1'b0);
        checkOutput("c_rdreq", 128'(bus.rd_req_o), 128'd1);
        checkOutput("c_addr", 128'(bus.rd_addr_o), 128'h8000_0010);
        checkOutput("c_blen", 128'(bus.rd_blen_o), 128'd1);
        checkOutput("c_id", 128'(bus.rd_id_o), 128'd0);
        doIdle(1'b1, 1'b0);
        checkOutput("c_rdreq_gnt", 128'(bus.rd_req_o), 128'd0);
        doBeat(4'd0, 64'hA, 1'b0, 1'b0);
        checkOutput("c_vld_early", 128'(bus.rtrn_vld_o), 128'd0);
        doBeat(4'd0, 64'hB, 1'b1, 1'b0);
        checkOutput("c_vld", 128'(bus.rtrn_vld_o), 128'd1);
        checkOutput("c_data", bus.rtrn_data_o, {64'hB, 64'hA});
        checkOutput("c_tid", 128'(bus.rtrn_tid_o), 128'd1);
        checkOutput("c_nc", 128'(bus.rtrn_nc_o), 128'd0);
        doIdle(1'b0, 1'b1);
        checkOutput("c_vld_done", 128'(bus.rtrn_vld_o), 128'd0);

        // Non-cacheable single beat
        doRequest(64'h1004, 1'b1, 2'd2, 1'b0);
        checkOutput("nc_addr", 128'(bus.rd_addr_o), 128'h1000);
        checkOutput("nc_blen", 128'(bus.rd_blen_o), 128'd0);
        doIdle(1'b1, 1'b0);
        doBeat(4'd0, 64'hC, 1'b1, 1'b0);
        checkOutput("nc_vld", 128'(bus.rtrn_vld_o), 128'd1);
        checkOutput("nc_data", bus.rtrn_data_o, 128'hC);
        checkOutput("nc_nc", 128'(bus.rtrn_nc_o), 128'd1);
        checkOutput("nc_tid", 128'(bus.rtrn_tid_o), 128'd2);
        doIdle(1'b0, 1'b1);

        // Two outstanding, beats interleaved across IDs
        doRequest(64'h2000, 1'b0, 2'd0, 1'b0);
        doRequest(64'h3000, 1'b0, 2'd3, 1'b1);
        checkOutput("il_id", 128'(bus.rd_id_o), 128'd1);
        checkOutput("il_addr", 128'(bus.rd_addr_o), 128'h3000);
        doIdle(1'b1, 1'b0);
        doBeat(4'd1, 64'h11, 1'b0, 1'b0);
        doBeat(4'd0, 64'h01, 1'b0, 1'b0);
        doBeat(4'd1, 64'h12, 1'b1, 1'b0);
        checkOutput("il_tid1", 128'(bus.rtrn_tid_o), 128'd3);
        checkOutput("il_data1", bus.rtrn_data_o, {64'h12, 64'h11});
        doBeat(4'd0, 64'h02, 1'b1, 1'b1);
        checkOutput("il_vld0", 128'(bus.rtrn_vld_o), 128'd1);
        checkOutput("il_tid0", 128'(bus.rtrn_tid_o), 128'd0);
        checkOutput("il_data0", bus.rtrn_data_o, {64'h02, 64'h01});
        doIdle(1'b0, 1'b1);
        checkOutput("il_vld_done", 128'(bus.rtrn_vld_o), 128'd0);

        // Both slots busy with grant withheld
        doRequest(64'h4000, 1'b0, 2'd1, 1'b0);
        doRequest(64'h5008, 1'b0, 2'd2, 1'b0);
        checkOutput("full_ready", 128'(bus.req_ready_o), 128'd0);
        checkOutput("full_id", 128'(bus.rd_id_o), 128'd0);
        checkOutput("full_addr", 128'(bus.rd_addr_o), 128'h4000);
        doIdle(1'b0, 1'b0);
        checkOutput("full_hold", 128'(bus.rd_addr_o), 128'h4000);
        doIdle(1'b1, 1'b0);
        checkOutput("full_next_id", 128'(bus.rd_id_o), 128'd1);
        checkOutput("full_next_addr", 128'(bus.rd_addr_o), 128'h5000);
        checkOutput("full_ready2", 128'(bus.req_ready_o), 128'd0);
        doIdle(1'b1, 1'b0);
        checkOutput("full_rdreq", 128'(bus.rd_req_o), 128'd0);

        // Return backpressure while the lower slot completes behind the presented one
        doBeat(4'd1, 64'h51, 1'b0, 1'b0);
        doBeat(4'd1, 64'h52, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) doBeat(4'd0, 64'h41, 1'b0, 1'b0);
            else if (i == 1) doBeat(4'd0, 64'h42, 1'b1, 1'b0);
            else doIdle(1'b0, 1'b0);
            checkOutput("bp_tid", 128'(bus.rtrn_tid_o), 128'd2);
            checkOutput("bp_data", bus.rtrn_data_o, {64'h52, 64'h51});
            checkOutput("bp_ready", 128'(bus.req_ready_o), 128'd0);
        end
        doIdle(1'b0, 1'b1);
        checkOutput("bp_freed", 128'(bus.req_ready_o), 128'd1);
        checkOutput("bp_tid0", 128'(bus.rtrn_tid_o), 128'd1);
        checkOutput("bp_data0", bus.rtrn_data_o, {64'h42, 64'h41});
        doIdle(1'b0, 1'b1);
        checkOutput("bp_vld_done", 128'(bus.rtrn_vld_o), 128'd0);

        // Unexpected beats: free slot and out-of-range ID
        doRequest(64'h6000, 1'b0, 2'd0, 1'b0);
        doIdle(1'b1, 1'b0);
        doBeat(4'd0, 64'h61, 1'b0, 1'b0);
        checkOutput("ux_quiet", 128'(bus.unexp_beat_o), 128'd0);
        doBeat(4'd1, 64'h99, 1'b0, 1'b0);
        checkOutput("ux_pulse", 128'(bus.unexp_beat_o), 128'd1);
        doIdle(1'b0, 1'b0);
        checkOutput("ux_clear", 128'(bus.unexp_beat_o), 128'd0);
        doBeat(4'd5, 64'h77, 1'b0, 1'b0);
        checkOutput("ux_range", 128'(bus.unexp_beat_o), 128'd1);
        doBeat(4'd0, 64'h62, 1'b1, 1'b0);
        checkOutput("ux_data", bus.rtrn_data_o, {64'h62, 64'h61});
        doIdle(1'b0, 1'b1);

        // Extra beats beyond a line are dropped
        doRequest(64'h8000, 1'b0, 2'd3, 1'b0);
        doIdle(1'b1, 1'b0);
        doBeat(4'd0, 64'h81, 1'b0, 1'b0);
        doBeat(4'd0, 64'h82, 1'b0, 1'b0);
        doBeat(4'd0, 64'h83, 1'b0, 1'b0);
        doBeat(4'd0, 64'h84, 1'b1, 1'b0);
        checkOutput("ov_data", bus.rtrn_data_o, {64'h82, 64'h81});
        doIdle(1'b0, 1'b1);

        // Reset mid-operation drops in-flight slots
        doRequest(64'h7000, 1'b0, 2'd1, 1'b0);
        doIdle(1'b1, 1'b0);
        rst = 1'b1;
        doIdle(1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("mr_ready", 128'(bus.req_ready_o), 128'd1);
        checkOutput("mr_rdreq", 128'(bus.rd_req_o), 128'd0);
        doBeat(4'd0, 64'h71, 1'b1, 1'b0);
        checkOutput("mr_unexp", 128'(bus.unexp_beat_o), 128'd1);
        checkOutput("mr_vld", 128'(bus.rtrn_vld_o), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
